// File: rtl/excp_ctrl_pkg.sv
// Shared exception definitions: cause codes, vector address, FSM encoding and mem_excp bit map.
// Also reused by cp0_reg.
package excp_ctrl_pkg;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  // Bit positions inside mem_excp_i
  localparam int EXCP_ADEL_IF = 0;
  localparam int EXCP_RI      = 1;
  localparam int EXCP_SYS     = 2;
  localparam int EXCP_BP      = 3;
  localparam int EXCP_OV      = 4;
  localparam int EXCP_TR      = 5;
  localparam int EXCP_ADEL_D  = 6;
  localparam int EXCP_ADES    = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } excp_state_t;

  typedef enum logic [1:0] {
    BADV_NONE = 2'd0,
    BADV_PC   = 2'd1,
    BADV_ADDR = 2'd2
  } badv_sel_t;

  function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
    return (|(cause[15:8] & status[15:8])) & status[0] & ~status[1];
  endfunction

endpackage

// File: rtl/excp_ctrl_prio.sv
// excp_prio_enc: combinational priority encoder from event flags to cause code and bad-address source.
module excp_prio_enc
  import excp_ctrl_pkg::*;
(
  input  logic [7:0]  excp,
  input  logic        int_pend,
  input  logic        eret,
  output logic        event_valid,
  output logic [31:0] code,
  output badv_sel_t   badv_sel
);

  always_comb begin
    event_valid = int_pend | (|excp) | eret;
    code        = '0;
    badv_sel    = BADV_NONE;
    if (int_pend) begin
      code = EXC_INT;
    end else if (excp[EXCP_ADEL_IF]) begin
      code     = EXC_ADEL;
      badv_sel = BADV_PC;
    end else if (excp[EXCP_RI]) begin
      code = EXC_RI;
    end else if (excp[EXCP_SYS]) begin
      code = EXC_SYS;
    end else if (excp[EXCP_BP]) begin
      code = EXC_BP;
    end else if (excp[EXCP_OV]) begin
      code = EXC_OV;
    end else if (excp[EXCP_TR]) begin
      code = EXC_TR;
    end else if (excp[EXCP_ADEL_D]) begin
      code     = EXC_ADEL;
      badv_sel = BADV_ADDR;
    end else if (excp[EXCP_ADES]) begin
      code     = EXC_ADES;
      badv_sel = BADV_ADDR;
    end else if (eret) begin
      code = EXC_ERET;
    end
  end

endmodule

// File: rtl/excp_ctrl.sv
// excp_ctrl: takes exceptions/ERET at mem stage, drains the bus, commits to cp0, then redirects fetch.
// Optional macro EXCP_DRAIN_TIMEOUT_EN adds a 256-cycle drain timeout and the drain_err_o flag.
module excp_ctrl
  import excp_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_ds_i,
  input  logic [7:0]  mem_excp_i,
  input  logic        mem_eret_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        bus_idle_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] pc_o,
  output logic [31:0] bad_vaddr_o,
  output logic        ds_o,
  output logic        flush_o,
  output logic        stall_req_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ack_i
`ifdef EXCP_DRAIN_TIMEOUT_EN
  ,
  output logic        drain_err_o
`endif
);

  excp_state_t state_reg;
  logic        int_pend;
  logic        ev_valid;
  logic [31:0] ev_code;
  badv_sel_t   ev_badv_sel;
  logic [31:0] ev_badv;
  logic        accept;
  logic        drain_timeout;

  logic [31:0] code_reg, pc_reg, badv_reg;
  logic        ds_reg;
  logic [31:0] excepttype_reg, pc_out_reg, badv_out_reg;
  logic        ds_out_reg, flush_reg;
  logic        redirect_valid_reg;
  logic [31:0] redirect_pc_reg;

  assign int_pend = int_pending(status_i, cause_i);

  excp_prio_enc u_prio (
    .excp        (mem_excp_i),
    .int_pend    (int_pend),
    .eret        (mem_eret_i),
    .event_valid (ev_valid),
    .code        (ev_code),
    .badv_sel    (ev_badv_sel)
  );

  always_comb begin
    ev_badv = '0;
    case (ev_badv_sel)
      BADV_PC:   ev_badv = mem_pc_i;
      BADV_ADDR: ev_badv = mem_addr_i;
      default:   ev_badv = '0;
    endcase
  end

  assign accept      = ~rst & (state_reg == ST_IDLE) & mem_valid_i & ev_valid;
  // Stall must rise in the acceptance cycle itself, before the state register moves.
  assign stall_req_o = ~rst & (accept | (state_reg != ST_IDLE));

`ifdef EXCP_DRAIN_TIMEOUT_EN
  logic [7:0] drain_cnt_reg;
  logic       drain_err_reg;

  assign drain_timeout = (drain_cnt_reg == 8'hff);
  assign drain_err_o   = drain_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt_reg <= '0;
      drain_err_reg <= 1'b0;
    end else if (accept) begin
      drain_cnt_reg <= '0;
    end else if (state_reg == ST_DRAIN) begin
      drain_cnt_reg <= drain_cnt_reg + 8'd1;
      if (drain_timeout && !bus_idle_i)
        drain_err_reg <= 1'b1;
    end
  end
`else
  assign drain_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= ST_IDLE;
      code_reg           <= '0;
      pc_reg             <= '0;
      badv_reg           <= '0;
      ds_reg             <= 1'b0;
      excepttype_reg     <= '0;
      pc_out_reg         <= '0;
      badv_out_reg       <= '0;
      ds_out_reg         <= 1'b0;
      flush_reg          <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            code_reg  <= ev_code;
            pc_reg    <= mem_pc_i;
            badv_reg  <= ev_badv;
            ds_reg    <= mem_ds_i;
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // cp0 outputs are loaded on the way into COMMIT so they are valid for exactly that cycle
          if (bus_idle_i || drain_timeout) begin
            excepttype_reg <= code_reg;
            pc_out_reg     <= pc_reg;
            badv_out_reg   <= badv_reg;
            ds_out_reg     <= ds_reg;
            flush_reg      <= 1'b1;
            state_reg      <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          excepttype_reg     <= '0;
          pc_out_reg         <= '0;
          badv_out_reg       <= '0;
          ds_out_reg         <= 1'b0;
          flush_reg          <= 1'b0;
          redirect_valid_reg <= 1'b1;
          redirect_pc_reg    <= (code_reg == EXC_ERET) ? epc_i : EXC_VECTOR;
          state_reg          <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (redirect_ack_i) begin
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
            state_reg          <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign excepttype_o     = excepttype_reg;
  assign pc_o             = pc_out_reg;
  assign bad_vaddr_o      = badv_out_reg;
  assign ds_o             = ds_out_reg;
  assign flush_o          = flush_reg;
  assign redirect_valid_o = redirect_valid_reg;
  assign redirect_pc_o    = redirect_pc_reg;

endmodule

// File: tb/tb_excp_ctrl.sv
// Scoreboard bench for excp_ctrl: expected commits are queued when an event is driven and popped on flush.
// Build with EXCP_DRAIN_TIMEOUT_EN to also exercise the drain timeout.
module tb_excp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid_i = 1'b0;
  logic [31:0] mem_pc_i = '0, mem_addr_i = '0;
  logic        mem_ds_i = 1'b0;
  logic [7:0]  mem_excp_i = '0;
  logic        mem_eret_i = 1'b0;
  logic [31:0] status_i = '0, cause_i = '0, epc_i = '0;
  logic        bus_idle_i = 1'b1;
  logic [31:0] excepttype_o, pc_o, bad_vaddr_o, redirect_pc_o;
  logic        ds_o, flush_o, stall_req_o, redirect_valid_o;
  logic        redirect_ack_i = 1'b0;
`ifdef EXCP_DRAIN_TIMEOUT_EN
  logic        drain_err_o;
`endif

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
    logic [31:0] badv;
    logic        ds;
    logic [31:0] rpc;
    int          lat;
    logic        derr;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  excp_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .mem_valid_i      (mem_valid_i),
    .mem_pc_i         (mem_pc_i),
    .mem_addr_i       (mem_addr_i),
    .mem_ds_i         (mem_ds_i),
    .mem_excp_i       (mem_excp_i),
    .mem_eret_i       (mem_eret_i),
    .status_i         (status_i),
    .cause_i          (cause_i),
    .epc_i            (epc_i),
    .bus_idle_i       (bus_idle_i),
    .excepttype_o     (excepttype_o),
    .pc_o             (pc_o),
    .bad_vaddr_o      (bad_vaddr_o),
    .ds_o             (ds_o),
    .flush_o          (flush_o),
    .stall_req_o      (stall_req_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ack_i   (redirect_ack_i)
`ifdef EXCP_DRAIN_TIMEOUT_EN
    ,
    .drain_err_o      (drain_err_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] code, input logic [31:0] pc, input logic [31:0] badv,
                              input logic ds, input logic [31:0] rpc, input int lat, input logic derr);
    exp_t e;
    e.code = code; e.pc = pc; e.badv = badv; e.ds = ds; e.rpc = rpc; e.lat = lat; e.derr = derr;
    return e;
  endfunction

  // idle_low: bus_idle_i is held 0 for this many cycles counted from the acceptance cycle.
  task automatic run_event(input string name, input logic [31:0] pc, input logic [31:0] addr,
                           input logic ds, input logic [7:0] excp, input logic eret,
                           input logic [31:0] status, input logic [31:0] cause, input logic [31:0] epc,
                           input int idle_low, input int ack_wait, input logic rst_in_redir,
                           input exp_t e);
    exp_t x;
    logic got;
    int   k_commit;
    got = 1'b0;
    k_commit = 0;
    @(negedge clk);
    mem_valid_i = 1'b1; mem_pc_i = pc; mem_addr_i = addr; mem_ds_i = ds;
    mem_excp_i = excp; mem_eret_i = eret;
    status_i = status; cause_i = cause; epc_i = epc;
    bus_idle_i = (idle_low == 0);
    sb.push_back(e);
    #1 chk({name, ".stall_accept"}, {31'b0, stall_req_o}, 32'd1);
    for (int k = 1; k <= 400 && !got; k++) begin
      @(negedge clk);
      // Garbage while busy: must be ignored outside IDLE.
      mem_excp_i = 8'h5a; mem_eret_i = 1'b1; mem_addr_i = 32'hdead_beef;
      bus_idle_i = (k >= idle_low);
      if (k == 1) begin
        chk({name, ".drain_quiet"}, excepttype_o | pc_o | bad_vaddr_o | {30'b0, ds_o, flush_o}, 32'd0);
        chk({name, ".drain_stall"}, {31'b0, stall_req_o}, 32'd1);
      end
      if (flush_o) begin
        got = 1'b1;
        k_commit = k;
      end
    end
    mem_valid_i = 1'b0; mem_excp_i = '0; mem_eret_i = 1'b0; bus_idle_i = 1'b1;
    x = sb.pop_front();
    if (!got) begin
      chk({name, ".commit_seen"}, 32'd0, 32'd1);
    end else begin
      $display("event %s: commit cycle %0d code %h pc %h badv %h ds %0d",
               name, k_commit, excepttype_o, pc_o, bad_vaddr_o, ds_o);
      chk({name, ".commit_lat"}, k_commit, x.lat);
      chk({name, ".code"}, excepttype_o, x.code);
      chk({name, ".pc"}, pc_o, x.pc);
      chk({name, ".badv"}, bad_vaddr_o, x.badv);
      chk({name, ".ds"}, {31'b0, ds_o}, {31'b0, x.ds});
`ifdef EXCP_DRAIN_TIMEOUT_EN
      chk({name, ".drain_err"}, {31'b0, drain_err_o}, {31'b0, x.derr});
`endif
      @(negedge clk);
      chk({name, ".redir_valid"}, {31'b0, redirect_valid_o}, 32'd1);
      chk({name, ".redir_pc"}, redirect_pc_o, x.rpc);
      chk({name, ".post_commit_clear"}, excepttype_o | pc_o | bad_vaddr_o | {30'b0, ds_o, flush_o}, 32'd0);
      if (rst_in_redir) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({name, ".rst_outputs"}, excepttype_o | pc_o | bad_vaddr_o | redirect_pc_o |
            {28'b0, ds_o, flush_o, stall_req_o, redirect_valid_o}, 32'd0);
      end else begin
        for (int w = 0; w < ack_wait; w++) begin
          @(negedge clk);
          chk({name, ".redir_hold"}, redirect_pc_o & {32{redirect_valid_o}}, x.rpc);
        end
        redirect_ack_i = 1'b1;
        @(negedge clk);
        redirect_ack_i = 1'b0;
        chk({name, ".idle_after_ack"}, {30'b0, redirect_valid_o, stall_req_o}, 32'd0);
      end
    end
    status_i = '0; cause_i = '0; epc_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset.outputs", excepttype_o | pc_o | bad_vaddr_o | redirect_pc_o |
        {28'b0, ds_o, flush_o, stall_req_o, redirect_valid_o}, 32'd0);
`ifdef EXCP_DRAIN_TIMEOUT_EN
    chk("reset.drain_err", {31'b0, drain_err_o}, 32'd0);
`endif
    rst = 1'b0;

    // Flags without mem_valid must not start anything.
    @(negedge clk);
    mem_excp_i = 8'h04;
    #1 chk("novalid.stall", {31'b0, stall_req_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("novalid.flush", {31'b0, flush_o | redirect_valid_o}, 32'd0);
    mem_excp_i = '0;

    run_event("syscall", 32'hBFC0_0100, 32'h0, 1'b0, 8'h04, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0,
              mk(32'h8, 32'hBFC0_0100, 32'h0, 1'b0, VEC, 2, 1'b0));
    run_event("int_ov_ds", 32'hBFC0_0200, 32'h0, 1'b1, 8'h10, 1'b0, 32'h0000_0401, 32'h0000_0400, 32'h0,
              0, 1, 1'b0, mk(32'h1, 32'hBFC0_0200, 32'h0, 1'b1, VEC, 2, 1'b0));
    run_event("eret", 32'hBFC0_0300, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0, 32'h0, 32'hBFC0_0840, 0, 3, 1'b0,
              mk(32'he, 32'hBFC0_0300, 32'h0, 1'b0, 32'hBFC0_0840, 2, 1'b0));
    run_event("ades_wait", 32'hBFC0_0400, 32'h8000_0003, 1'b0, 8'h80, 1'b0, 32'h0, 32'h0, 32'h0, 10, 0, 1'b0,
              mk(32'h5, 32'hBFC0_0400, 32'h8000_0003, 1'b0, VEC, 11, 1'b0));
    run_event("adelif_ri", 32'hBFC0_0502, 32'h1111_0000, 1'b0, 8'h03, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0,
              mk(32'h4, 32'hBFC0_0502, 32'hBFC0_0502, 1'b0, VEC, 2, 1'b0));
    run_event("ri_sys", 32'hBFC0_0600, 32'h0, 1'b0, 8'h06, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0,
              mk(32'ha, 32'hBFC0_0600, 32'h0, 1'b0, VEC, 2, 1'b0));
    run_event("bp_ov", 32'hBFC0_0700, 32'h0, 1'b1, 8'h18, 1'b0, 32'h0, 32'h0, 32'h0, 2, 0, 1'b0,
              mk(32'h9, 32'hBFC0_0700, 32'h0, 1'b1, VEC, 3, 1'b0));
    run_event("trap_adeld", 32'hBFC0_0800, 32'h0000_1235, 1'b0, 8'h60, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0,
              mk(32'hd, 32'hBFC0_0800, 32'h0, 1'b0, VEC, 2, 1'b0));
    run_event("adeld_eret", 32'hBFC0_0900, 32'h0000_1235, 1'b0, 8'h40, 1'b1, 32'h0, 32'h0, 32'h8000_1000,
              0, 0, 1'b0, mk(32'h4, 32'hBFC0_0900, 32'h0000_1235, 1'b0, VEC, 2, 1'b0));
    run_event("exl_eret", 32'hBFC0_0a00, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0000_0403, 32'h0000_0400,
              32'h8000_1000, 0, 0, 1'b0, mk(32'he, 32'hBFC0_0a00, 32'h0, 1'b0, 32'h8000_1000, 2, 1'b0));
    run_event("exl_ov", 32'hBFC0_0b00, 32'h0, 1'b0, 8'h10, 1'b0, 32'h0000_0403, 32'h0000_0400, 32'h0,
              0, 0, 1'b0, mk(32'hc, 32'hBFC0_0b00, 32'h0, 1'b0, VEC, 2, 1'b0));
    run_event("rst_redir", 32'hBFC0_0c00, 32'h0, 1'b1, 8'h04, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1,
              mk(32'h8, 32'hBFC0_0c00, 32'h0, 1'b1, VEC, 2, 1'b0));
    run_event("after_rst", 32'hBFC0_0d00, 32'h0, 1'b0, 8'h08, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0,
              mk(32'h9, 32'hBFC0_0d00, 32'h0, 1'b0, VEC, 2, 1'b0));
`ifdef EXCP_DRAIN_TIMEOUT_EN
    run_event("timeout", 32'hBFC0_0e00, 32'h0, 1'b0, 8'h10, 1'b0, 32'h0, 32'h0, 32'h0, 1000, 0, 1'b0,
              mk(32'hc, 32'hBFC0_0e00, 32'h0, 1'b0, VEC, 257, 1'b1));
    chk("timeout.sticky", {31'b0, drain_err_o}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("timeout.rst_clear", {31'b0, drain_err_o}, 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
